// File: rtl/mmio_io_ctrl.sv
// Memory-mapped KEY/SW/LED/HEX block: synchronised + debounced inputs, sticky W1C press flags, masked irq.
// Reads are combinational, writes land on the strobe edge; IO_DEBOUNCE_EN compiles in the per-bit debouncers.
module mmio_io_ctrl #(
  parameter int                 DBITS           = 32,
  parameter logic [DBITS-1:0]   BASE_ADDR       = 32'hF0000000,
  parameter int                 KEY_BITS        = 4,
  parameter int                 SW_BITS         = 10,
  parameter int                 LEDR_BITS       = 10,
  parameter int                 LEDG_BITS       = 8,
  parameter int                 HEX_DIGITS      = 4,
  parameter int                 DEBOUNCE_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DBITS-1:0]        addr,
  input  logic                    wrtEn,
  input  logic [DBITS-1:0]        wrtData,
  input  logic [KEY_BITS-1:0]     key_in,
  input  logic [SW_BITS-1:0]      sw_in,
  output logic                    hit,
  output logic [DBITS-1:0]        rdData,
  output logic [LEDR_BITS-1:0]    ledr,
  output logic [LEDG_BITS-1:0]    ledg,
  output logic [7*HEX_DIGITS-1:0] hex,
  output logic                    irq
);

  localparam int HEX_W = 4 * HEX_DIGITS;

  localparam logic [2:0] SEL_HEX  = 3'd0;
  localparam logic [2:0] SEL_LEDR = 3'd1;
  localparam logic [2:0] SEL_LEDG = 3'd2;
  localparam logic [2:0] SEL_KEY  = 3'd4;
  localparam logic [2:0] SEL_SW   = 3'd5;
  localparam logic [2:0] SEL_EDGE = 3'd6;
  localparam logic [2:0] SEL_MASK = 3'd7;

  logic [2:0]          sel;
  logic                wr;
  logic [HEX_W-1:0]    hex_reg;
  logic [KEY_BITS-1:0] edge_reg;
  logic [KEY_BITS-1:0] mask_reg;
  logic [KEY_BITS-1:0] edge_clr;
  logic [KEY_BITS-1:0] key_rise;

  logic [KEY_BITS-1:0] key_s1, key_s2, key_db;
  logic [SW_BITS-1:0]  sw_s1, sw_s2, sw_db;

  assign hit = (addr[DBITS-1:5] == BASE_ADDR[DBITS-1:5]);
  assign sel = addr[4:2];
  assign wr  = hit & wrtEn;

  // Keys are inverted ahead of the synchroniser so every stage resets to "released".
  always_ff @(posedge clk) begin
    if (reset) begin
      key_s1 <= '0;
      key_s2 <= '0;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      key_s1 <= ~key_in;
      key_s2 <= key_s1;
      sw_s1  <= sw_in;
      sw_s2  <= sw_s1;
    end
  end

`ifdef IO_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] key_cnt [KEY_BITS];
  logic [CW-1:0] sw_cnt  [SW_BITS];

  always_ff @(posedge clk) begin
    if (reset) begin
      key_db <= '0;
      sw_db  <= '0;
      for (int i = 0; i < KEY_BITS; i++) key_cnt[i] <= '0;
      for (int i = 0; i < SW_BITS; i++)  sw_cnt[i]  <= '0;
    end else begin
      for (int i = 0; i < KEY_BITS; i++) begin
        if (key_s2[i] != key_db[i]) begin
          if (key_cnt[i] == CNT_LAST) begin
            key_db[i]  <= key_s2[i];
            key_cnt[i] <= '0;
          end else begin
            key_cnt[i] <= key_cnt[i] + 1'b1;
          end
        end else begin
          key_cnt[i] <= '0;
        end
      end
      for (int i = 0; i < SW_BITS; i++) begin
        if (sw_s2[i] != sw_db[i]) begin
          if (sw_cnt[i] == CNT_LAST) begin
            sw_db[i]  <= sw_s2[i];
            sw_cnt[i] <= '0;
          end else begin
            sw_cnt[i] <= sw_cnt[i] + 1'b1;
          end
        end else begin
          sw_cnt[i] <= '0;
        end
      end
    end
  end

  // A press qualifies on the edge where the debounced bit is about to go 0->1.
  always_comb begin
    key_rise = '0;
    for (int i = 0; i < KEY_BITS; i++)
      key_rise[i] = key_s2[i] & ~key_db[i] & (key_cnt[i] == CNT_LAST);
  end

  logic unused_ok;
  assign unused_ok = ^{addr[1:0], wrtData};
`else
  assign key_db   = key_s2;
  assign sw_db    = sw_s2;
  assign key_rise = key_s1 & ~key_s2;

  logic unused_ok;
  assign unused_ok = ^{addr[1:0], wrtData, DEBOUNCE_CYCLES};
`endif

  assign edge_clr = (wr && sel == SEL_EDGE) ? wrtData[KEY_BITS-1:0] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      hex_reg  <= '0;
      ledr     <= '0;
      ledg     <= '0;
      mask_reg <= '0;
      edge_reg <= '0;
    end else begin
      if (wr) begin
        case (sel)
          SEL_HEX:  hex_reg  <= wrtData[HEX_W-1:0];
          SEL_LEDR: ledr     <= wrtData[LEDR_BITS-1:0];
          SEL_LEDG: ledg     <= wrtData[LEDG_BITS-1:0];
          SEL_MASK: mask_reg <= wrtData[KEY_BITS-1:0];
          default:  ;
        endcase
      end
      // A new press on the same edge as its W1C keeps the flag set.
      edge_reg <= (edge_reg & ~edge_clr) | key_rise;
    end
  end

  assign irq = |(edge_reg & mask_reg);

  always_comb begin
    rdData = '0;
    if (hit) begin
      case (sel)
        SEL_HEX:  rdData[HEX_W-1:0]     = hex_reg;
        SEL_LEDR: rdData[LEDR_BITS-1:0] = ledr;
        SEL_LEDG: rdData[LEDG_BITS-1:0] = ledg;
        SEL_KEY:  rdData[KEY_BITS-1:0]  = key_db;
        SEL_SW:   rdData[SW_BITS-1:0]   = sw_db;
        SEL_EDGE: rdData[KEY_BITS-1:0]  = edge_reg;
        SEL_MASK: rdData[KEY_BITS-1:0]  = mask_reg;
        default:  ;
      endcase
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    hex = '0;
    for (int d = 0; d < HEX_DIGITS; d++)
      hex[7*d +: 7] = seg7(hex_reg[4*d +: 4]);
  end

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Randomised + directed bench for mmio_io_ctrl against a history-based behavioural model.
module tb_mmio_io_ctrl;
  localparam int DC = 16;
`ifdef IO_DEBOUNCE_EN
  localparam int LAT = 2 + DC;
`else
  localparam int LAT = 2;
`endif
  localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wrtData, rdData;
  logic        wrtEn, hit, irq;
  logic [3:0]  key_in;
  logic [9:0]  sw_in, ledr;
  logic [7:0]  ledg;
  logic [27:0] hex;

  mmio_io_ctrl #(
    .DBITS(32), .BASE_ADDR(32'hF0000000), .KEY_BITS(4), .SW_BITS(10),
    .LEDR_BITS(10), .LEDG_BITS(8), .HEX_DIGITS(4), .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .wrtEn(wrtEn), .wrtData(wrtData),
    .key_in(key_in), .sw_in(sw_in), .hit(hit), .rdData(rdData),
    .ledr(ledr), .ledg(ledg), .hex(hex), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: raw samples (keys as 1=pressed in [3:0], switches in [13:4]).
  logic [15:0] m_hex;
  logic [9:0]  m_ledr, m_sw;
  logic [7:0]  m_ledg;
  logic [3:0]  m_key, m_edge, m_mask;
  logic [13:0] raw_q[$];
  logic [13:0] seen_q[$];

  function automatic bit in_window(input logic [31:0] a);
    return (a & 32'hFFFF_FFE0) == 32'hF000_0000;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    if (!in_window(a)) return 32'h0;
    case (a[4:2])
      3'd0: return {16'h0, m_hex};
      3'd1: return {22'h0, m_ledr};
      3'd2: return {24'h0, m_ledg};
      3'd4: return {28'h0, m_key};
      3'd5: return {22'h0, m_sw};
      3'd6: return {28'h0, m_edge};
      3'd7: return {28'h0, m_mask};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [27:0] exp_hex();
    logic [27:0] h;
    for (int d = 0; d < 4; d++) h[7*d +: 7] = GLYPH[m_hex[4*d +: 4]];
    return h;
  endfunction

  always @(posedge clk) begin
    logic [13:0] synced, db_old, db_new;
    logic [3:0]  clr;
    bit          all_other;
    if (reset) begin
      m_hex = '0; m_ledr = '0; m_ledg = '0; m_key = '0; m_sw = '0; m_edge = '0; m_mask = '0;
      raw_q = '{14'h0, 14'h0};
      seen_q.delete();
    end else begin
      // The synchronised value seen before this edge is the raw sample from two edges earlier.
      synced = raw_q[0];
      db_old = {m_sw, m_key};
`ifdef IO_DEBOUNCE_EN
      seen_q.push_back(synced);
      if (seen_q.size() > DC) void'(seen_q.pop_front());
      db_new = db_old;
      if (seen_q.size() == DC) begin
        for (int b = 0; b < 14; b++) begin
          all_other = 1'b1;
          foreach (seen_q[j]) if (seen_q[j][b] == db_old[b]) all_other = 1'b0;
          if (all_other) db_new[b] = ~db_old[b];
        end
      end
`else
      db_new = raw_q[1];
`endif
      clr = (in_window(addr) && wrtEn && addr[4:2] == 3'd6) ? wrtData[3:0] : 4'h0;
      m_edge = (m_edge & ~clr) | (db_new[3:0] & ~m_key);
      if (in_window(addr) && wrtEn) begin
        case (addr[4:2])
          3'd0: m_hex  = wrtData[15:0];
          3'd1: m_ledr = wrtData[9:0];
          3'd2: m_ledg = wrtData[7:0];
          3'd7: m_mask = wrtData[3:0];
          default: ;
        endcase
      end
      m_key = db_new[3:0];
      m_sw  = db_new[13:4];
      void'(raw_q.pop_front());
      raw_q.push_back({sw_in, ~key_in});
    end
    #1;
    if (chk_en) begin
      check("hit", hit, in_window(addr));
      check("rdData", rdData, exp_rd(addr));
      check("ledr", ledr, m_ledr);
      check("ledg", ledg, m_ledg);
      check("hex", hex, exp_hex());
      check("irq", irq, |(m_edge & m_mask));
    end
  end

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr = a; wrtData = d; wrtEn = 1'b1;
    @(negedge clk);
    wrtEn = 1'b0; addr = 32'h0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a; wrtEn = 1'b0;
    #1 d = rdData;
  endtask

  task automatic wait_key(input logic [31:0] want, output int n, output logic irq_prev);
    n = 0; irq_prev = irq;
    addr = 32'hF000_0010;
    while (n < 100) begin
      @(posedge clk); #2;
      n++;
      if (rdData == want) break;
      irq_prev = irq;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic        irq_prev;
    int          n;
    reset = 1'b1; addr = 32'h0; wrtEn = 1'b0; wrtData = 32'h0; key_in = 4'hF; sw_in = 10'h0;
    @(negedge clk); chk_en = 1'b1;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    check("rst_ledr", ledr, 10'h0);
    check("rst_ledg", ledg, 8'h0);
    check("rst_hex", hex, {4{7'b1000000}});
    check("rst_irq", irq, 1'b0);
    rd(32'hF000_0018, d); check("rst_edge", d, 32'h0);

    store(32'hF000_0000, 32'h0000_12AF);
    check("hex_12af", hex, {7'h79, 7'h24, 7'h08, 7'h0E});
    rd(32'hF000_0003, d); check("rd_hex_unaligned", d, 32'h12AF);

    store(32'hF000_001C, 32'h1);
    @(negedge clk);
    key_in = 4'b1110;
    wait_key(32'h1, n, irq_prev);
    check("key_latency", n, LAT);
    check("irq_on_qualify_edge", irq, 1'b1);
    check("irq_before_qualify", irq_prev, 1'b0);
    @(negedge clk);
    key_in = 4'hF;
    repeat (LAT + 4) @(negedge clk);
    rd(32'hF000_0018, d); check("edge_kept_on_release", d, 32'h1);
    rd(32'hF000_0010, d); check("key_released", d, 32'h0);

`ifdef IO_DEBOUNCE_EN
    key_in[1] = 1'b0;
    repeat (10) @(negedge clk);
    key_in[1] = 1'b1;
    repeat (30) @(negedge clk);
    rd(32'hF000_0010, d); check("glitch_key", d, 32'h0);
    rd(32'hF000_0018, d); check("glitch_edge", d, 32'h1);
`endif

    store(32'hF000_001C, 32'h0); check("irq_masked", irq, 1'b0);
    store(32'hF000_001C, 32'h1); check("irq_unmasked", irq, 1'b1);
    store(32'hF000_0018, 32'h1); check("irq_after_w1c", irq, 1'b0);
    rd(32'hF000_0018, d); check("edge_after_w1c", d, 32'h0);

    key_in = 4'b1110;
    repeat (LAT - 1) @(negedge clk);
    store(32'hF000_0018, 32'h1);
    check("set_beats_w1c_irq", irq, 1'b1);
    rd(32'hF000_0018, d); check("set_beats_w1c_edge", d, 32'h1);
    key_in = 4'hF;
    repeat (LAT + 4) @(negedge clk);
    store(32'hF000_0018, 32'hF);

    store(32'hF000_0020, 32'hFFFF);
    store(32'hE000_0000, 32'hFFFF);
    store(32'hF000_0004 ^ 32'h0100_0000, 32'h3FF);
    store(32'hF000_000C, 32'hFFFF_FFFF);
    check("decode_hex_kept", hex, {7'h79, 7'h24, 7'h08, 7'h0E});
    check("decode_ledr_kept", ledr, 10'h0);
    rd(32'hF000_0020, d); check("miss_hi_rd", d, 32'h0); check("miss_hi_hit", hit, 1'b0);
    rd(32'hE000_0000, d); check("miss_lo_rd", d, 32'h0); check("miss_lo_hit", hit, 1'b0);
    rd(32'hF000_000C, d); check("reserved_rd", d, 32'h0);

    key_in = 4'b1101;
    repeat (12) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_key(32'h2, n, irq_prev);
    check("key_latency_after_reset", n, LAT);
    @(negedge clk);
    key_in = 4'hF;

    for (int i = 0; i < 3000; i++) begin
      logic [3:0] kb;
      reset = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 29) == 0) begin kb = 4'(1 << $urandom_range(0, 3)); key_in = key_in ^ kb; end
      if ($urandom_range(0, 29) == 0) sw_in = sw_in ^ 10'($urandom_range(1, 1023));
      case ($urandom_range(0, 3))
        0, 1, 2: addr = 32'hF000_0000 | 32'($urandom_range(0, 31));
        default: addr = $urandom;
      endcase
      wrtEn   = ($urandom_range(0, 2) == 0);
      wrtData = $urandom;
      @(negedge clk);
    end
    reset = 1'b0; wrtEn = 1'b0; addr = 32'h0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mmio_io_ctrl.md
# mmio_io_ctrl

Parametrised memory-mapped I/O controller for the single-cycle core. It replaces the fixed KEY/SW/HEX/LEDR/LEDG address decode with a configurable-width peripheral block. The block adds input synchronisation and debounce, sticky key-press capture with write-1-to-clear, and an interrupt mask. It sits on the data-memory port beside data memory: the core drives address, write enable and data, and muxes `rdData` in when `hit` is high.

## Interface
- `DBITS`, 32, address and data width
- `BASE_ADDR`, 32'hF0000000, base of the 32-byte register window
- `KEY_BITS`, 4, number of push-button channels (1..DBITS)
- `SW_BITS`, 10, number of switch channels (1..DBITS)
- `LEDR_BITS`, 10, red LED width (1..DBITS)
- `LEDG_BITS`, 8, green LED width (1..DBITS)
- `HEX_DIGITS`, 4, number of 7-segment digits (1..8)
- `DEBOUNCE_CYCLES`, 16, stable cycles required before an input change is accepted (>=2)

Ports:
- `clk` in, 1: system clock
- `reset` in, 1: synchronous, active-high
- `addr` in, DBITS: byte address from the core
- `wrtEn` in, 1: store strobe
- `wrtData` in, DBITS: store data
- `key_in` in, KEY_BITS: raw buttons, active-low
- `sw_in` in, SW_BITS: raw switches, active-high
- `hit` out, 1: `addr` falls inside the window
- `rdData` out, DBITS: read data, combinational
- `ledr` out, LEDR_BITS: red LEDs
- `ledg` out, LEDG_BITS: green LEDs
- `hex` out, 7*HEX_DIGITS: segments, active-low; digit i occupies bits [7i+6:7i], g..a
- `irq` out, 1: OR of (EDGE & MASK)

## Operation
- Decode: `hit` = (addr[DBITS-1:5] == BASE_ADDR[DBITS-1:5]). Register select = addr[4:2]. addr[1:0] is ignored.
- Register map, by byte offset:
  - 0x00 HEX, RW: 4*HEX_DIGITS bits, one nibble per digit.
  - 0x04 LEDR, RW.
  - 0x08 LEDG, RW.
  - 0x0C reserved: reads 0, writes ignored.
  - 0x10 KEY, RO: debounced level; 1 = pressed, i.e. inverted `key_in`.
  - 0x14 SW, RO: debounced level.
  - 0x18 EDGE, RW1C: sticky press flags.
  - 0x1C MASK, RW: irq enable per key.
- Writes take effect when `hit & wrtEn`. Unused upper bits are dropped on write and read as 0. Writes to RO registers are ignored.
- Reads are side-effect free. `rdData` = 0 when `hit`=0.
- Input path, per bit: 2-flop synchroniser, then debouncer. Each bit has a counter of width clog2(DEBOUNCE_CYCLES).
  - The counter increments while the synchronised value differs from the debounced value, and clears otherwise.
  - When a mismatch persists and the counter equals DEBOUNCE_CYCLES-1, the debounced bit takes the new value on that edge and the counter clears.
- EDGE[i] sets on the edge where debounced KEY[i] goes 0->1. It clears when written with 1; writing 0 has no effect.
- Set and W1C in the same cycle: set wins, and the bit stays 1.
- Release (1->0) never sets EDGE.
- HEX decode is combinational from the HEX register: standard 0-F glyphs, active-low.

## Timing
- Reset values:
  - ledr=0, ledg=0.
  - HEX reg=0, so every digit shows "0" (7'b1000000).
  - Synchronisers, counters and debounced KEY/SW are 0.
  - EDGE=0, MASK=0, irq=0.
- Reset asserted mid-debounce discards the partial count. After reset, an input held since before reset is re-qualified from zero.
- Write latency: the register and its output change at the clock edge that samples `wrtEn`.
- Read latency: 0 cycles. `rdData` follows `addr` combinationally, which suits a single-cycle load.
- Input latency, for a stable raw change: the debounced value updates 2 + DEBOUNCE_CYCLES edges later. EDGE sets on that same edge, and `irq` rises combinationally right after it if masked in.
- A glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no change. Its counter resets on the first matching cycle.
- All channels are independent. Simultaneous presses set their EDGE bits on their own qualifying edges.

## Configuration
- `IO_DEBOUNCE_EN` defined: the debouncers are compiled in, as described above.
- `IO_DEBOUNCE_EN` undefined: the debouncers and counters are removed. The debounced value equals the synchroniser output, giving 2-edge input latency. EDGE and MASK behaviour is otherwise unchanged, and `DEBOUNCE_CYCLES` is ignored.

## Test plan
- Reset: hold `reset` 3 cycles. Expect ledr=0, ledg=0, hex = 4×7'b1000000, irq=0. Read 0x18 → 0.
- Write: store 0xF000_0000 with data 0x0000_12AF. Next cycle: hex digits 0..3 = F,A,2,1 glyphs. Read at addr 0xF000_0003 → 0x12AF.
- Debounce (macro on, DEBOUNCE_CYCLES=16):
  - Drive key_in=4'b1110 stable. Expect KEY read = 0x1 exactly 18 edges later, and EDGE=0x1 on the same edge.
  - A 10-cycle low pulse on key_in[1] yields no change.
- IRQ and W1C:
  - Write MASK=0x1 with EDGE[0]=1 → irq=1.
  - Store 0x1 to 0x18 → EDGE=0 and irq=0 next cycle.
  - Store 0x1 on the edge where a new press qualifies → EDGE stays 1.
- Decode: addr=0xF000_0020 or 0xE000_0000 → hit=0, rdData=0, and stores change nothing. Read 0x0C → 0.
- Reset mid-debounce: assert reset at count 10 with the key held. After release, KEY becomes 1 only 18 edges later.
